// File: rtl/ddr_pkg.sv
// ddr_pkg: shared FSM states, bus widths and LFSR constants for the DDR responder
package ddr_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} ddr_state_t;
    localparam int DDR_INDEX_W = 19;
    localparam int DDR_WORD_W = 64;
    localparam int DDR_BURST_BEATS = 8;
    localparam int DDR_BURST_W = 512;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/ddr_resp_lfsr.sv
// ddr_resp_lfsr: 16-bit Fibonacci LFSR giving 0..7 extra wait cycles per accepted request
module ddr_resp_lfsr
    import ddr_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    output logic [2:0] extra
);
    logic [15:0] q;

    always_ff @(posedge clock or posedge reset)
        if (reset) q <= LFSR_SEED;
        else if (advance) q <= {q[14:0], ^(q & LFSR_TAPS)};

    assign extra = q[2:0];
endmodule

// File: rtl/ddr_mem_responder.sv
// ddr_mem_responder: fixed-latency 64-bit word memory answering core DDR loads, stores and 8-word bursts
// Define DDR_RESP_RANDOM_LATENCY_EN to add 0..7 LFSR-driven extra wait cycles per request.
module ddr_mem_responder
    import ddr_pkg::*;
#(
    parameter int DEPTH = 65536,
    parameter int LATENCY = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ddr_chip_enable,
    input  logic [DDR_INDEX_W-1:0] ddr_index,
    input  logic                   ddr_write_enable,
    input  logic                   ddr_burst_mode,
    input  logic [DDR_WORD_W-1:0]  ddr_opstore_write_mask,
    input  logic [DDR_WORD_W-1:0]  ddr_opstore_write_data,
    output logic [DDR_WORD_W-1:0]  ddr_opload_read_data,
    output logic [DDR_BURST_W-1:0] ddr_pc_read_inst,
    output logic                   ddr_operation_done,
    output logic                   ddr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 8);

    ddr_state_t state, state_next;
    logic [DDR_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] idx_q, cur_idx, rd_addr;
    logic we_q, burst_q, cur_we, cur_burst;
    logic [DDR_WORD_W-1:0] mask_q, data_q, cur_mask, cur_data, rd_word;
    logic [CW-1:0] cnt, wait_len;
    logic [2:0] beat, extra;
    logic [DDR_BURST_W-1:0] inst_buf, buf_next;
    logic accept, capture, fin, unused_idx_hi;

`ifdef DDR_RESP_RANDOM_LATENCY_EN
    ddr_resp_lfsr u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .advance(accept),
        .extra  (extra)
    );
`else
    assign extra = 3'd0;
`endif

    assign unused_idx_hi = ^(ddr_index >> AW);
    assign accept = state == IDLE && ddr_chip_enable;
    // In IDLE the request is still on the bus; afterwards use the latched copy
    assign cur_idx = state == IDLE ? ddr_index[AW-1:0] : idx_q;
    assign cur_we = state == IDLE ? ddr_write_enable : we_q;
    assign cur_burst = state == IDLE ? ddr_burst_mode & ~ddr_write_enable : burst_q;
    assign cur_mask = state == IDLE ? ddr_opstore_write_mask : mask_q;
    assign cur_data = state == IDLE ? ddr_opstore_write_data : data_q;
    assign wait_len = CW'(LATENCY - 1) + CW'(extra);
    assign rd_addr = cur_burst ? {cur_idx[AW-1:3], beat} : cur_idx;
    assign rd_word = mem[rd_addr];

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        ddr_ready = 1'b0;
        ddr_operation_done = 1'b0;
        case (state)
            IDLE: begin
                ddr_ready = 1'b1;
                if (ddr_chip_enable) state_next = wait_len != '0 ? WAIT : (cur_burst ? BEAT : DONE);
            end
            WAIT: if (cnt == CW'(1)) state_next = cur_burst ? BEAT : DONE;
            BEAT: if (beat == 3'd7) state_next = DONE;
            DONE: begin
                ddr_operation_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A beat is captured on the edge into BEAT and on every edge leaving BEAT
    assign capture = cur_burst && (state_next == BEAT || state == BEAT);
    assign fin = state_next == DONE;

    always_comb begin
        buf_next = inst_buf;
        buf_next[beat*DDR_WORD_W +: DDR_WORD_W] = rd_word;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            idx_q <= '0;
            we_q <= 1'b0;
            burst_q <= 1'b0;
            mask_q <= '0;
            data_q <= '0;
            cnt <= '0;
            beat <= '0;
            inst_buf <= '0;
            ddr_opload_read_data <= '0;
            ddr_pc_read_inst <= '0;
        end else begin
            if (accept) begin
                idx_q <= cur_idx;
                we_q <= cur_we;
                burst_q <= cur_burst;
                mask_q <= cur_mask;
                data_q <= cur_data;
            end
            cnt <= accept ? wait_len : (state == WAIT ? cnt - CW'(1) : cnt);
            if (capture) begin
                beat <= beat + 3'd1;
                inst_buf <= buf_next;
            end
            if (fin && cur_burst) ddr_pc_read_inst <= buf_next;
            if (fin && !cur_burst && !cur_we) ddr_opload_read_data <= rd_word;
        end

    always_ff @(posedge clock)
        if (!reset && fin && cur_we) mem[cur_idx] <= (mem[cur_idx] & ~cur_mask) | (cur_data & cur_mask);
endmodule

// File: tb/tb_ddr_mem_responder.sv
// tb_ddr_mem_responder: randomized self-checking bench against a word-array reference model
module tb_ddr_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LATENCY = 4;

    logic clock, reset, ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
    logic [18:0] ddr_index;
    logic [63:0] ddr_opstore_write_mask, ddr_opstore_write_data, ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic ddr_operation_done, ddr_ready;

    int checks = 0;
    int errors = 0;
    logic [63:0] mem_m [int];
    logic [63:0] exp_load;
    logic [511:0] exp_inst;

    ddr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset), .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_opstore_write_mask(ddr_opstore_write_mask), .ddr_opstore_write_data(ddr_opstore_write_data),
        .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
        .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int min_lat(input bit burst);
        return burst ? LATENCY + 7 : LATENCY;
    endfunction

    function automatic int max_lat(input bit burst);
`ifdef DDR_RESP_RANDOM_LATENCY_EN
        return min_lat(burst) + 7;
`else
        return min_lat(burst);
`endif
    endfunction

    task automatic launch(input logic we, input logic burst, input logic [18:0] idx,
                          input logic [63:0] mask, input logic [63:0] data);
        ddr_chip_enable = 1'b1;
        ddr_write_enable = we;
        ddr_burst_mode = burst;
        ddr_index = idx;
        ddr_opstore_write_mask = mask;
        ddr_opstore_write_data = data;
        @(posedge clock);
        #1;
        ddr_chip_enable = 1'b0;
        ddr_write_enable = 1'($urandom);
        ddr_index = 19'($urandom);
        ddr_opstore_write_data = {$urandom, $urandom};
    endtask

    // Runs one request to completion, reports latency and handshake sanity, updates the model
    task automatic issue(input logic we, input logic burst, input logic [18:0] idx,
                         input logic [63:0] mask, input logic [63:0] data,
                         output int lat, output bit ok);
        int a;
        ok = 1'b1;
        lat = -1;
        for (int i = 0; i < 50 && ddr_ready !== 1'b1; i++) @(negedge clock);
        if (ddr_ready !== 1'b1) ok = 1'b0;
        launch(we, burst, idx, mask, data);
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clock);
            if (ddr_ready !== 1'b0) ok = 1'b0;
            if (ddr_operation_done === 1'b1) lat = n;
        end
        @(negedge clock);
        if (ddr_operation_done !== 1'b0 || ddr_ready !== 1'b1 || lat < 0) ok = 1'b0;
        a = int'(idx) & (DEPTH - 1);
        if (lat > 0) begin
            if (we) mem_m[a] = (mem_m[a] & ~mask) | (data & mask);
            else if (burst) for (int k = 0; k < 8; k++) exp_inst[64*k +: 64] = mem_m[(a & ~7) + k];
            else exp_load = mem_m[a];
        end
    endtask

    task automatic preload(input int a, input logic [63:0] v);
        int lat;
        bit ok;
        issue(1'b1, 1'b0, 19'(a), '1, v, lat, ok);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ddr_chip_enable = 1'b0;
        ddr_write_enable = 1'b0;
        ddr_burst_mode = 1'b0;
        ddr_index = '0;
        ddr_opstore_write_mask = '0;
        ddr_opstore_write_data = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_load = '0;
        exp_inst = '0;
        @(negedge clock);
        checks++; if (ddr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ddr_ready); end
        checks++; if (ddr_operation_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", ddr_operation_done); end
        checks++; if (ddr_opload_read_data !== 64'h0) begin errors++; $display("FAIL rst_load: got %h want 0", ddr_opload_read_data); end
        checks++; if (ddr_pc_read_inst !== 512'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", ddr_pc_read_inst); end
    endtask

    task automatic test_write_read;
        int lat;
        bit ok;
        issue(1'b1, 1'b0, 19'h10, '1, 64'h1122334455667788, lat, ok);
        checks++; if (lat < min_lat(0) || lat > max_lat(0)) begin errors++; $display("FAIL wr_lat: got %0d want %0d..%0d", lat, min_lat(0), max_lat(0)); end
        checks++; if (!ok) begin errors++; $display("FAIL wr_handshake: got bad want clean"); end
        checks++; if (ddr_opload_read_data !== 64'h0) begin errors++; $display("FAIL wr_load_hold: got %h want 0", ddr_opload_read_data); end
        issue(1'b0, 1'b0, 19'h10, '0, '0, lat, ok);
        checks++; if (lat < min_lat(0) || lat > max_lat(0)) begin errors++; $display("FAIL rd_lat: got %0d want %0d..%0d", lat, min_lat(0), max_lat(0)); end
        checks++; if (!ok) begin errors++; $display("FAIL rd_handshake: got bad want clean"); end
        checks++; if (ddr_opload_read_data !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data: got %h want 1122334455667788", ddr_opload_read_data); end
    endtask

    task automatic test_partial_mask;
        int lat;
        bit ok;
        issue(1'b1, 1'b0, 19'h10, 64'h00000000FFFFFFFF, 64'hAAAAAAAABBBBBBBB, lat, ok);
        issue(1'b0, 1'b0, 19'h10, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== 64'h11223344BBBBBBBB) begin errors++; $display("FAIL mask_data: got %h want 11223344BBBBBBBB", ddr_opload_read_data); end
    endtask

    task automatic test_burst;
        int lat;
        bit ok;
        logic [63:0] want;
        for (int k = 0; k < 8; k++) preload(16 + k, 64'(256 + k));
        issue(1'b0, 1'b1, 19'h13, '0, '0, lat, ok);
        checks++; if (lat < min_lat(1) || lat > max_lat(1)) begin errors++; $display("FAIL burst_lat: got %0d want %0d..%0d", lat, min_lat(1), max_lat(1)); end
        checks++; if (!ok) begin errors++; $display("FAIL burst_handshake: got bad want clean"); end
        for (int k = 0; k < 8; k++) begin
            want = 64'(256 + k);
            checks++; if (ddr_pc_read_inst[64*k +: 64] !== want) begin errors++; $display("FAIL burst_beat%0d: got %h want %h", k, ddr_pc_read_inst[64*k +: 64], want); end
        end
        checks++; if (ddr_opload_read_data !== 64'h11223344BBBBBBBB) begin errors++; $display("FAIL burst_load_hold: got %h want 11223344BBBBBBBB", ddr_opload_read_data); end
    endtask

    task automatic test_conflict;
        int lat;
        bit ok;
        issue(1'b1, 1'b1, 19'h18, '1, 64'hC0FFEE0012345678, lat, ok);
        checks++; if (lat < min_lat(0) || lat > max_lat(0)) begin errors++; $display("FAIL conf_lat: got %0d want %0d..%0d", lat, min_lat(0), max_lat(0)); end
        checks++; if (ddr_pc_read_inst !== exp_inst) begin errors++; $display("FAIL conf_inst_hold: got %h want %h", ddr_pc_read_inst, exp_inst); end
        issue(1'b0, 1'b0, 19'h18, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== 64'hC0FFEE0012345678) begin errors++; $display("FAIL conf_data: got %h want C0FFEE0012345678", ddr_opload_read_data); end
    endtask

    task automatic test_busy;
        int dones = 0;
        int lat;
        bit ok;
        logic [63:0] old30;
        preload(32, {$urandom, $urandom});
        preload(48, {$urandom, $urandom});
        old30 = mem_m[48];
        launch(1'b0, 1'b0, 19'h20, '0, '0);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (ddr_operation_done === 1'b1) dones++;
            if (n == 2) begin
                ddr_chip_enable = 1'b1;
                ddr_write_enable = 1'b1;
                ddr_burst_mode = 1'b0;
                ddr_index = 19'h30;
                ddr_opstore_write_mask = '1;
                ddr_opstore_write_data = ~old30;
            end
            if (n == 5) ddr_chip_enable = 1'b0;
        end
        ddr_chip_enable = 1'b0;
        exp_load = mem_m[32];
        checks++; if (dones !== 1) begin errors++; $display("FAIL busy_dones: got %0d want 1", dones); end
        checks++; if (ddr_opload_read_data !== exp_load) begin errors++; $display("FAIL busy_load: got %h want %h", ddr_opload_read_data, exp_load); end
        issue(1'b0, 1'b0, 19'h30, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== old30) begin errors++; $display("FAIL busy_untouched: got %h want %h", ddr_opload_read_data, old30); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        int lat;
        bit ok;
        for (int k = 0; k < 8; k++) preload(72 + k, {$urandom, $urandom});
        launch(1'b0, 1'b1, 19'h48, '0, '0);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clock);
            if (ddr_operation_done === 1'b1) dones++;
        end
        reset = 1'b1;
        #1;
        exp_load = '0;
        exp_inst = '0;
        checks++; if (ddr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ddr_ready); end
        checks++; if (ddr_opload_read_data !== 64'h0) begin errors++; $display("FAIL mid_load: got %h want 0", ddr_opload_read_data); end
        checks++; if (ddr_pc_read_inst !== 512'h0) begin errors++; $display("FAIL mid_inst: got %h want 0", ddr_pc_read_inst); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (ddr_operation_done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL mid_dones: got %0d want 0", dones); end
        issue(1'b0, 1'b0, 19'h4A, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== mem_m[74]) begin errors++; $display("FAIL mid_mem: got %h want %h", ddr_opload_read_data, mem_m[74]); end
        launch(1'b1, 1'b0, 19'h49, '1, ~mem_m[73]);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_load = '0;
        @(negedge clock);
        issue(1'b0, 1'b0, 19'h49, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== mem_m[73]) begin errors++; $display("FAIL mid_store_drop: got %h want %h", ddr_opload_read_data, mem_m[73]); end
    endtask

    task automatic test_wrap;
        int lat;
        bit ok;
        issue(1'b1, 1'b0, 19'h00400, '1, 64'h5A, lat, ok);
        issue(1'b0, 1'b0, 19'h00000, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== 64'h5A) begin errors++; $display("FAIL wrap_low: got %h want 5a", ddr_opload_read_data); end
        issue(1'b0, 1'b0, 19'h7FC00, '0, '0, lat, ok);
        checks++; if (ddr_opload_read_data !== 64'h5A) begin errors++; $display("FAIL wrap_high: got %h want 5a", ddr_opload_read_data); end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit ok;
        logic [8:0] hi;
        for (int a = 0; a < 64; a++) preload(a, {$urandom, $urandom});
        for (int i = 0; i < 50; i++) begin
            hi = 9'($urandom);
            issue(1'b0, 1'b0, {hi, 10'($urandom_range(0, 63))}, '0, '0, lat, ok);
            checks++; if (lat < min_lat(0) || lat > max_lat(0)) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d want %0d..%0d", i, lat, min_lat(0), max_lat(0)); end
            checks++; if (!ok) begin errors++; $display("FAIL b2b_handshake[%0d]: got bad want clean", i); end
            checks++; if (ddr_opload_read_data !== exp_load) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ddr_opload_read_data, exp_load); end
        end
    endtask

    task automatic test_random;
        int lat;
        bit ok;
        logic we, burst;
        logic [8:0] hi;
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 2);
            we = r == 1;
            burst = r == 2 || (we && $urandom_range(0, 3) == 0);
            hi = 9'($urandom);
            issue(we, burst, {hi, 10'($urandom_range(0, 63))}, {$urandom, $urandom}, {$urandom, $urandom}, lat, ok);
            checks++; if (lat < min_lat(burst && !we) || lat > max_lat(burst && !we)) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d..%0d", i, lat, min_lat(burst && !we), max_lat(burst && !we)); end
            checks++; if (!ok) begin errors++; $display("FAIL rnd_handshake[%0d]: got bad want clean", i); end
            checks++; if (ddr_opload_read_data !== exp_load) begin errors++; $display("FAIL rnd_load[%0d]: got %h want %h", i, ddr_opload_read_data, exp_load); end
            checks++; if (ddr_pc_read_inst !== exp_inst) begin errors++; $display("FAIL rnd_inst[%0d]: got %h want %h", i, ddr_pc_read_inst, exp_inst); end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_partial_mask;
        test_burst;
        test_conflict;
        test_busy;
        test_reset_mid;
        test_wrap;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_mem_responder.md
Name: ddr_mem_responder

Overview:
- Responder end of the core's DDR request interface: accepts single-word loads/stores and 8-word instruction bursts, and answers with ready/done and read data.
- Sits outside the core (SoC/sim top), wired port-for-port to the core's ddr_* signals.
- Backed by a synchronous 64-bit word memory with a configurable fixed access latency.
- Serves as the bring-up memory and the reference responder for core-level verification.

Parameters:
- DEPTH, 65536: number of 64-bit words; power of two, at most 2^19; address = low log2(DEPTH) bits of ddr_index.
- LATENCY, 4: cycles from request acceptance to ddr_operation_done for a single access; must be at least 1.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ddr_chip_enable  input  1  request strobe; accepted only while ddr_ready=1.
- ddr_index  input  19  64-bit word index.
- ddr_write_enable  input  1  1=store, 0=load.
- ddr_burst_mode  input  1  1=8-word instruction burst read.
- ddr_opstore_write_mask  input  64  per-bit write mask.
- ddr_opstore_write_data  input  64  store data.
- ddr_opload_read_data  output  64  single-word load result.
- ddr_pc_read_inst  output  512  burst result; word k in bits [64k+63:64k].
- ddr_operation_done  output  1  one-cycle completion pulse.
- ddr_ready  output  1  idle, able to accept a request.

Behaviour:
- Reset values: ddr_ready=1, ddr_operation_done=0, ddr_opload_read_data=0, ddr_pc_read_inst=0, FSM=IDLE, counters=0.
- Memory contents are not reset.
- FSM states:
  - IDLE: ddr_ready=1. chip_enable=1 latches index, write_enable, burst_mode, mask and data; ddr_ready drops the next cycle. Next state is WAIT.
  - WAIT: counts down LATENCY-1 cycles. Then goes to DONE for a single access, or to BEAT for a burst.
  - BEAT: burst only. Reads one word per cycle; 7 further cycles after the first beat.
  - DONE: ddr_operation_done=1 for exactly one cycle, ddr_ready=0. Next state is IDLE; ddr_ready returns to 1 the following cycle.
- Latency, counting the acceptance edge as cycle 0:
  - Single access: done at cycle LATENCY.
  - Burst: done at cycle LATENCY+7.
  - Back-to-back issue: a new request can be accepted no earlier than one cycle after done.
- Store: mem[a] <= (mem[a] & ~mask) | (data & mask), committed on the DONE edge. A load issued after done observes the store.
- Load: ddr_opload_read_data updates in the DONE cycle. It holds its value until the next completed load; stores and bursts do not change it.
- Burst:
  - Base address = index with bits [2:0] cleared.
  - Words base+0..base+7 land in ddr_pc_read_inst beats 0..7.
  - The output updates in the DONE cycle and holds until the next completed burst.
- Conflicting request: burst_mode=1 together with write_enable=1 is treated as a single store; burst_mode is ignored.
- Busy: chip_enable while ddr_ready=0 is ignored. Nothing is queued and no extra done is produced.
- Address wrap: index bits above log2(DEPTH) are discarded. A burst never crosses the aligned 8-word block.
- Reset during an operation: returns to IDLE immediately and no done is produced. A pending store is dropped; memory is otherwise unchanged.

Optional Feature:
- Macro: DDR_RESP_RANDOM_LATENCY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted request.
  - Its low 3 bits add 0..7 extra WAIT cycles per request.
  - Done timing still obeys all handshake rules above.
- Undefined: latency is exactly LATENCY (or LATENCY+7 for a burst), and the LFSR is not present.

Decomposition:
- Shared package ddr_pkg holds:
  - FSM state enum (IDLE, WAIT, BEAT, DONE);
  - DDR_INDEX_W=19, DDR_WORD_W=64, DDR_BURST_BEATS=8, DDR_BURST_W=512;
  - LFSR seed and taps.
- One sub-module: ddr_resp_lfsr (LFSR plus extra-latency output), instantiated only under DDR_RESP_RANDOM_LATENCY_EN.

Test Plan:
- Write then read (LATENCY=4): reset; store idx 0x10, data 0x1122334455667788, mask all ones.
  - ddr_ready=0 on cycles 1-4 after acceptance; done pulses at cycle 4.
  - A load of idx 0x10 then returns 0x1122334455667788 with done at cycle 4.
- Partial mask: store idx 0x10, data 0xAAAAAAAABBBBBBBB, mask 0x00000000FFFFFFFF.
  - A subsequent load returns 0x11223344BBBBBBBB.
- Aligned burst: preload words 0x10..0x17 with values 0x100+k, then burst at idx 0x13.
  - ddr_pc_read_inst beat k = 0x100+k.
  - Done at cycle 11; ddr_opload_read_data unchanged.
- Busy request: during a load of idx 0x20, pulse chip_enable with idx 0x30 (store).
  - Exactly one done; mem[0x30] unchanged; the load returns mem[0x20].
- Mid-burst reset: assert reset at cycle 6 of a burst.
  - No done pulse; ddr_ready=1; outputs=0.
  - A later load of a preloaded word returns its prior value.
- Address wrap (DEPTH=1024): store 0x5A at idx 0x00400.
  - A load of idx 0x00000 returns 0x5A.
- Random latency (macro defined): 50 back-to-back loads.
  - Every latency is in [LATENCY, LATENCY+7].
  - Exactly one done per accepted request; data correct.
